sign_extender: RTL and testbench
================================

SIGN_EXTENDER -- requirements
Module: sign_extender

Interface
REQ-001 Parameter IN_W, default 6, SHALL set the immediate field width (legal range 2..16).
REQ-002 Parameter OUT_W, default 32, SHALL set the extended word width (legal range IN_W+2..64).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports named as the codebase does:
- clk  input  1  rising-edge clock for the registered path.
- reset  input  1  asynchronous, active-high reset.
- imm  input  IN_W  raw immediate field; bit IN_W-1 is the sign bit.
- in_valid  input  1  qualifies imm/mode for the registered path.
- mode  input  2  registered-path extension mode (see REQ-007).
- signExtImm  output  OUT_W  combinational sign extension of imm.
- ext_out  output  OUT_W  registered, mode-dependent extension.
- out_valid  output  1  ext_out holds a result captured from a valid input.

Function
REQ-004 signExtImm SHALL equal imm[IN_W-1] replicated into bits OUT_W-1..IN_W, with imm in bits IN_W-1..0.
REQ-005 signExtImm SHALL have zero latency and SHALL be independent of clk, reset, in_valid and mode.
REQ-006 signExtImm SHALL be purely combinational, with no latch, and SHALL settle within one delta of any imm change.
REQ-007 The mode encoding SHALL be:
- 00: sign-extend.
- 01: zero-extend (upper bits 0).
- 10: sign-extend then shift left 2 (branch offset); bits 1..0 = 0.
- 11: imm placed in bits OUT_W-1..OUT_W-IN_W, remaining bits 0 (upper-immediate).
REQ-008 On a rising clk edge with in_valid=1, ext_out SHALL load the REQ-007 result of the current imm/mode, and out_valid SHALL become 1.
REQ-009 On a rising clk edge with in_valid=0, ext_out SHALL hold its value, and out_valid SHALL become 0.
REQ-010 Registered-path latency SHALL be exactly one clock cycle, with a throughput of one result per cycle and no backpressure.
REQ-011 In mode 10, bits shifted beyond OUT_W-1 SHALL be discarded; no overflow flag exists.
REQ-012 A mode or imm change with in_valid=0 SHALL NOT affect ext_out.
REQ-013 Any X/Z value on mode while in_valid=1 is illegal; the bench SHALL flag it with an assertion.

Reset
REQ-014 While reset=1, ext_out SHALL be 0 and out_valid SHALL be 0, immediately and without waiting for clk.
REQ-015 Reset asserted mid-operation SHALL discard any captured result.
REQ-016 The first capture after reset SHALL occur on the first rising clk edge at which reset=0 and in_valid=1.
REQ-017 signExtImm SHALL be unaffected by reset.

Structure
REQ-018 The mode encodings (MODE_SEXT, MODE_ZEXT, MODE_BOFS, MODE_UPPER) and the default widths SHALL live in the shared package mips_pkg.
REQ-019 The combinational extension SHALL be one sub-module, ext_core (inputs imm, mode; output word).
REQ-020 ext_core SHALL be instantiated twice: once with mode tied to 00 for signExtImm, and once for the registered path.
REQ-021 A parameter check SHALL abort elaboration when IN_W or OUT_W is outside its legal range.

Verification
REQ-022 imm=6'b000011 -> signExtImm=0x00000003; imm=6'b011111 -> 0x0000001F; imm=6'b011100 -> 0x0000001C.
REQ-023 imm=6'b100011 -> signExtImm=0xFFFFFFE3; imm=6'b100111 -> 0xFFFFFFE7; imm=6'b111111 -> 0xFFFFFFFF; each settles with no clock edge.
REQ-024 in_valid=1, imm=6'b100011, one rising edge per mode:
- mode 00 -> ext_out=0xFFFFFFE3.
- mode 01 -> 0x00000023.
- mode 10 -> 0xFFFFFF8C.
- mode 11 -> 0x8C000000.
- out_valid=1 one cycle after each capture.
REQ-025 Capture imm=6'b000111 with mode 00, then drop in_valid and change imm/mode -> ext_out holds 0x00000007, and out_valid=0 from the next edge.
REQ-026 Assert reset between clock edges while ext_out is nonzero -> ext_out=0 and out_valid=0 immediately, while signExtImm still tracks imm.
REQ-027 Release reset with in_valid=1 and imm=6'b111111, mode 00 -> ext_out=0xFFFFFFFF after the first post-release edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths, immediate-extension mode encodings and parameter legality helpers
// used by the sign extender and its combinational core.
package mips_pkg;

    localparam int DEF_IN_W  = 6;
    localparam int DEF_OUT_W = 32;

    localparam int MIN_IN_W  = 2;
    localparam int MAX_IN_W  = 16;
    localparam int MAX_OUT_W = 64;
    // The branch-offset mode needs at least two bits of headroom above the field.
    localparam int MIN_GUARD = 2;

    typedef logic [1:0] ext_mode_t;

    localparam ext_mode_t MODE_SEXT  = 2'b00;
    localparam ext_mode_t MODE_ZEXT  = 2'b01;
    localparam ext_mode_t MODE_BOFS  = 2'b10;
    localparam ext_mode_t MODE_UPPER = 2'b11;

    function automatic logic in_w_legal(input int in_w);
        return (in_w >= MIN_IN_W) && (in_w <= MAX_IN_W);
    endfunction

    function automatic logic out_w_legal(input int in_w, input int out_w);
        return (out_w >= (in_w + MIN_GUARD)) && (out_w <= MAX_OUT_W);
    endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extender: widens an IN_W-bit field to OUT_W bits
// according to the selected extension mode.
module ext_core
    import mips_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic [IN_W-1:0]  imm,
    input  ext_mode_t        mode,
    output logic [OUT_W-1:0] word
);

    logic [OUT_W-1:0] sext_s;
    logic [OUT_W-1:0] zext_s;
    logic [OUT_W-1:0] bofs_s;
    logic [OUT_W-1:0] upper_s;

    assign sext_s  = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    assign zext_s  = {{(OUT_W-IN_W){1'b0}}, imm};
    // Bits pushed past the top of the word are simply dropped.
    assign bofs_s  = {sext_s[OUT_W-3:0], 2'b00};
    assign upper_s = {imm, {(OUT_W-IN_W){1'b0}}};

    // Select the extension result for the requested mode.
    always_comb begin
        word = {OUT_W{1'b0}};
        case (mode)
            MODE_SEXT:  word = sext_s;
            MODE_ZEXT:  word = zext_s;
            MODE_BOFS:  word = bofs_s;
            MODE_UPPER: word = upper_s;
            default:    word = {OUT_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/sign_extender.sv
// Immediate sign extender: a zero-latency sign-extended copy of imm plus a
// one-cycle registered path that applies a selectable extension mode.
module sign_extender
    import mips_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  imm,
    input  logic             in_valid,
    input  ext_mode_t        mode,
    output logic [OUT_W-1:0] signExtImm,
    output logic [OUT_W-1:0] ext_out,
    output logic             out_valid
);

    if (!in_w_legal(IN_W)) begin : g_bad_in_w
        $error("sign_extender: IN_W=%0d outside 2..16", IN_W);
    end

    if (!out_w_legal(IN_W, OUT_W)) begin : g_bad_out_w
        $error("sign_extender: OUT_W=%0d outside IN_W+2..64", OUT_W);
    end

    logic [OUT_W-1:0] sext_word_s;
    logic [OUT_W-1:0] mode_word_s;
    logic [OUT_W-1:0] ext_out_r;
    logic             out_valid_r;

    // Fixed sign-extend copy; never touches the clock or reset.
    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_sext_core (
        .imm  (imm),
        .mode (MODE_SEXT),
        .word (sext_word_s)
    );

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_mode_core (
        .imm  (imm),
        .mode (mode),
        .word (mode_word_s)
    );

    // Capture the mode-dependent result on valid cycles; hold the data otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_out_r   <= {OUT_W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (in_valid) begin
            ext_out_r   <= mode_word_s;
            out_valid_r <= 1'b1;
        end else begin
            ext_out_r   <= ext_out_r;
            out_valid_r <= 1'b0;
        end
    end

    assign signExtImm = sext_word_s;
    assign ext_out    = ext_out_r;
    assign out_valid  = out_valid_r;

endmodule

// File: tb/tb_sign_extender.sv
// Self-checking bench for sign_extender with the default 6-bit to 32-bit widths,
// checked against an arithmetic reference model.
module tb_sign_extender;

    logic        clk;
    logic        reset;
    logic [5:0]  imm;
    logic        in_valid;
    logic [1:0]  mode;
    logic [31:0] sign_ext_imm;
    logic [31:0] ext_out;
    logic        out_valid;

    int n_checks;
    int n_fail;

    sign_extender #(
        .IN_W  (6),
        .OUT_W (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imm        (imm),
        .in_valid   (in_valid),
        .mode       (mode),
        .signExtImm (sign_ext_imm),
        .ext_out    (ext_out),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // An unknown mode on a valid cycle is illegal input.
    always @(posedge clk) begin
        if (reset === 1'b0 && in_valid === 1'b1) begin
            assert (!$isunknown(mode)) else $error("mode is X/Z while in_valid=1");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Reference: signed value of the field, then plain integer arithmetic mod 2^32.
    function automatic logic [31:0] model(input logic [5:0] i, input logic [1:0] m);
        longint u;
        longint s;
        longint r;
        u = longint'(i);
        s = (u >= 32) ? (u - 64) : u;
        case (m)
            2'd0:    r = s;
            2'd1:    r = u;
            2'd2:    r = s * 4;
            2'd3:    r = u * 67108864;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; mode = 2'b00; imm = 6'b101010;
        #1;
        n_checks++;
        if (ext_out !== 32'h0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: ext_out=%h out_valid=%b, required 0/0", ext_out, out_valid);
        end
        tick();
        n_checks++;
        if (ext_out !== 32'h0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_edge: ext_out=%h out_valid=%b, required 0/0", ext_out, out_valid);
        end
        n_checks++;
        if (sign_ext_imm !== model(imm, 2'd0)) begin
            n_fail++;
            $display("FAIL reset_comb: signExtImm=%h, required %h", sign_ext_imm, model(imm, 2'd0));
        end
        in_valid = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_comb_vectors();
        logic [5:0] vec [6];
        vec = '{6'b000011, 6'b011111, 6'b011100, 6'b100011, 6'b100111, 6'b111111};
        for (int k = 0; k < 6; k++) begin
            imm = vec[k];
            mode = 2'(k);
            #1;
            n_checks++;
            if (sign_ext_imm !== model(vec[k], 2'd0)) begin
                n_fail++;
                $display("FAIL comb_vec%0d: signExtImm=%h, required %h", k, sign_ext_imm, model(vec[k], 2'd0));
            end
        end
    endtask

    task automatic test_modes();
        in_valid = 1'b1;
        imm = 6'b100011;
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            tick();
            n_checks++;
            if (ext_out !== model(6'b100011, 2'(m)) || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL mode%0d: ext_out=%h out_valid=%b, required %h/1",
                         m, ext_out, out_valid, model(6'b100011, 2'(m)));
            end
        end
    endtask

    task automatic test_hold();
        in_valid = 1'b1; imm = 6'b000111; mode = 2'b00;
        tick();
        n_checks++;
        if (ext_out !== 32'h0000_0007 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_capture: ext_out=%h out_valid=%b, required 00000007/1", ext_out, out_valid);
        end
        in_valid = 1'b0; imm = 6'b110001; mode = 2'b11;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (ext_out !== 32'h0000_0007 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: ext_out=%h out_valid=%b, required 00000007/0", c, ext_out, out_valid);
            end
            imm = 6'b010101; mode = 2'b10;
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; imm = 6'b000101; mode = 2'b01;
        tick();
        #2;
        reset = 1'b1;
        imm = 6'b110000;
        #1;
        n_checks++;
        if (ext_out !== 32'h0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: ext_out=%h out_valid=%b, required 0/0", ext_out, out_valid);
        end
        n_checks++;
        if (sign_ext_imm !== 32'hFFFF_FFF0) begin
            n_fail++;
            $display("FAIL async_reset_comb: signExtImm=%h, required fffffff0", sign_ext_imm);
        end
    endtask

    task automatic test_release();
        in_valid = 1'b1; imm = 6'b111111; mode = 2'b00;
        tick();
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (ext_out !== 32'h0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_pre: ext_out=%h out_valid=%b, required 0/0", ext_out, out_valid);
        end
        tick();
        n_checks++;
        if (ext_out !== 32'hFFFF_FFFF || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL release_first: ext_out=%h out_valid=%b, required ffffffff/1", ext_out, out_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_out;
        logic        exp_valid;
        exp_out = ext_out;
        exp_valid = out_valid;
        for (int n = 0; n < 300; n++) begin
            reset    = ($urandom_range(0, 15) == 0);
            in_valid = 1'($urandom_range(0, 1));
            imm      = 6'($urandom);
            mode     = 2'($urandom);
            #1;
            n_checks++;
            if (sign_ext_imm !== model(imm, 2'd0)) begin
                n_fail++;
                $display("FAIL rand_comb%0d: signExtImm=%h, required %h", n, sign_ext_imm, model(imm, 2'd0));
            end
            if (reset) begin
                exp_out = 32'h0;
                exp_valid = 1'b0;
            end else if (in_valid) begin
                exp_out = model(imm, mode);
                exp_valid = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
            tick();
            n_checks++;
            if (ext_out !== exp_out || out_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL rand_reg%0d: ext_out=%h out_valid=%b, required %h/%b",
                         n, ext_out, out_valid, exp_out, exp_valid);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_comb_vectors();
        test_modes();
        test_hold();
        test_async_reset();
        test_release();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
